// File: rtl/multiplier_csa_pkg.sv
// Shared types and helpers for the carry-save array multiplier.
package multiplier_csa_pkg;

    typedef struct packed {
        logic sum;
        logic cout;
    } fa_res_t;

    function automatic int prod_width(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/multiplier_csa_fa.sv
// One full-adder cell, used for every array cell and every final-adder bit.
module csa_full_adder
    import multiplier_csa_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    fa_res_t res;

    always_comb begin
        res.sum  = a ^ b ^ cin;
        res.cout = (a & b) | (cin & (a ^ b));
    end

    assign sum  = res.sum;
    assign cout = res.cout;

endmodule

// File: rtl/multiplier_csa.sv
// Unsigned N x N carry-save array multiplier with a single registered output stage.
module multiplier_csa
    import multiplier_csa_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic [2*N-1:0]   product,
    output logic             out_valid
);

    localparam int PW = prod_width(N);

    logic [PW-1:0] prod_c;
    logic [PW-1:0] product_d, product_q;
    logic          out_valid_d, out_valid_q;

    // Row r holds sums at weight r+j and carries at weight r+j+1; each row
    // consumes the previous row's sums shifted down one column, so carries
    // move diagonally and never ripple within a row.
    generate
        for (genvar r = 0; r < N; r++) begin : g_row
            logic [N-1:0] pp;
            logic [N-1:0] s;
            logic [N-1:0] c;

            assign pp = multiplicand & {N{multiplier[r]}};

            if (r == 0) begin : g_init
                assign s = pp;
                assign c = '0;
            end else begin : g_add
                logic [N-1:0] s_in;
                assign s_in = {1'b0, g_row[r-1].s[N-1:1]};
                for (genvar j = 0; j < N; j++) begin : g_cell
                    csa_full_adder u_fa (
                        .a    (pp[j]),
                        .b    (s_in[j]),
                        .cin  (g_row[r-1].c[j]),
                        .sum  (s[j]),
                        .cout (c[j])
                    );
                end
            end

            assign prod_c[r] = s[0];
        end

        // Ripple row resolving the leftover sum/carry vectors into the upper half.
        for (genvar k = 0; k < N; k++) begin : g_fin
            logic fa_a;
            logic ci;
            logic so;

            if (k < N - 1) begin : g_a
                assign fa_a = g_row[N-1].s[k+1];
            end else begin : g_a_top
                assign fa_a = 1'b0;
            end

            if (k == 0) begin : g_ci0
                assign ci = 1'b0;
            end else begin : g_ci
                assign ci = g_fin[k-1].co;
            end

            if (k < N - 1) begin : g_mid
                logic co_k;
                csa_full_adder u_fa (
                    .a    (fa_a),
                    .b    (g_row[N-1].c[k]),
                    .cin  (ci),
                    .sum  (so),
                    .cout (co_k)
                );
            end else begin : g_top
                logic carry_unused;
                csa_full_adder u_fa (
                    .a    (fa_a),
                    .b    (g_row[N-1].c[k]),
                    .cin  (ci),
                    .sum  (so),
                    .cout (carry_unused)
                );
            end

            logic co;
            if (k < N - 1) begin : g_co
                assign co = g_mid.co_k;
            end else begin : g_co_top
                assign co = 1'b0;
            end

            assign prod_c[N+k] = so;
        end
    endgenerate

    always_comb begin
        product_d   = in_valid ? prod_c : product_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign product   = product_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_csa.sv
// Directed and sweep checks of multiplier_csa at N=4, plus random sweeps at N=8 and N=16.
module tb_multiplier_csa;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        v4, ov4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    logic        v8, ov8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        v16, ov16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multiplier_csa #(.N(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(v4),
        .multiplicand(a4), .multiplier(b4), .product(p4), .out_valid(ov4)
    );

    multiplier_csa #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8),
        .multiplicand(a8), .multiplier(b8), .product(p8), .out_valid(ov8)
    );

    multiplier_csa #(.N(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16),
        .multiplicand(a16), .multiplier(b16), .product(p16), .out_valid(ov16)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; v4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (p4 !== 8'd0) begin bad++; $display("FAIL reset_product cyc=%0d got=%0d exp=0", i, p4); end
            total++;
            if (ov4 !== 1'b0) begin bad++; $display("FAIL reset_valid cyc=%0d got=%0b exp=0", i, ov4); end
        end
        rst_n = 1'b1; v4 = 1'b0;
        step();
        total++;
        if (p4 !== 8'd0 || ov4 !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle got=%0d/%0b exp=0/0", p4, ov4);
        end
    endtask

    task automatic test_directed;
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic [7:0] ve [4];
        va = '{4'd3, 4'd15, 4'd11, 4'd15};
        vb = '{4'd5, 4'd1,  4'd15, 4'd15};
        ve = '{8'd15, 8'd15, 8'd165, 8'd225};
        for (int i = 0; i < 4; i++) begin
            a4 = va[i]; b4 = vb[i]; v4 = 1'b1;
            if (i == 0) begin
                #1;
                total++;
                if (p4 !== 8'd0) begin bad++; $display("FAIL latency_pre_edge got=%0d exp=0", p4); end
            end
            step();
            total++;
            if (p4 !== ve[i]) begin bad++; $display("FAIL directed_%0d got=%0d exp=%0d", i, p4, ve[i]); end
            total++;
            if (ov4 !== 1'b1) begin bad++; $display("FAIL directed_valid_%0d got=%0b exp=1", i, ov4); end
        end
        v4 = 1'b0; a4 = 4'd1; b4 = 4'd1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (p4 !== 8'd225 || ov4 !== 1'b0) begin
                bad++; $display("FAIL hold_225 cyc=%0d got=%0d/%0b exp=225/0", i, p4, ov4);
            end
        end
    endtask

    task automatic test_zero_hold;
        a4 = 4'd0; b4 = 4'd13; v4 = 1'b1;
        step();
        total++;
        if (p4 !== 8'd0 || ov4 !== 1'b1) begin
            bad++; $display("FAIL zero_operand got=%0d/%0b exp=0/1", p4, ov4);
        end
        v4 = 1'b0; a4 = 4'd9; b4 = 4'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (p4 !== 8'd0 || ov4 !== 1'b0) begin
                bad++; $display("FAIL zero_hold cyc=%0d got=%0d/%0b exp=0/0", i, p4, ov4);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic [7:0] ve [3];
        va = '{4'd7, 4'd12, 4'd1};
        vb = '{4'd9, 4'd12, 4'd0};
        ve = '{8'd63, 8'd144, 8'd0};
        for (int i = 0; i < 3; i++) begin
            a4 = va[i]; b4 = vb[i]; v4 = 1'b1;
            step();
            total++;
            if (p4 !== ve[i] || ov4 !== 1'b1) begin
                bad++; $display("FAIL b2b_%0d got=%0d/%0b exp=%0d/1", i, p4, ov4, ve[i]);
            end
        end
        v4 = 1'b0;
        step();
        total++;
        if (ov4 !== 1'b0) begin bad++; $display("FAIL b2b_drain_valid got=%0b exp=0", ov4); end
    endtask

    task automatic test_reset_mid;
        a4 = 4'd10; b4 = 4'd10; v4 = 1'b1; rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (p4 !== 8'd0 || ov4 !== 1'b0) begin
                bad++; $display("FAIL reset_mid cyc=%0d got=%0d/%0b exp=0/0", i, p4, ov4);
            end
        end
        rst_n = 1'b1; a4 = 4'd6; b4 = 4'd7;
        step();
        total++;
        if (p4 !== 8'd42 || ov4 !== 1'b1) begin
            bad++; $display("FAIL after_reset_first got=%0d/%0b exp=42/1", p4, ov4);
        end
        v4 = 1'b0;
        step();
        total++;
        if (p4 !== 8'd42 || ov4 !== 1'b0) begin
            bad++; $display("FAIL after_reset_hold got=%0d/%0b exp=42/0", p4, ov4);
        end
    endtask

    task automatic test_exhaustive;
        logic [7:0] exp;
        v4 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                a4 = 4'(a); b4 = 4'(b);
                exp = 8'(a * b);
                step();
                total++;
                if (p4 !== exp || ov4 !== 1'b1) begin
                    bad++; $display("FAIL exh a=%0d b=%0d got=%0d/%0b exp=%0d/1", a, b, p4, ov4, exp);
                end
            end
        end
        v4 = 1'b0;
        step();
    endtask

    task automatic test_random_wide;
        logic [15:0] e8;
        logic [31:0] e16;
        v8 = 1'b1; v16 = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            a8  = 8'($urandom);  b8  = 8'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            if (i == 0) begin a8 = 8'hFF; b8 = 8'hFF; a16 = 16'hFFFF; b16 = 16'hFFFF; end
            e8  = {8'd0, a8} * {8'd0, b8};
            e16 = {16'd0, a16} * {16'd0, b16};
            step();
            total++;
            if (p8 !== e8 || ov8 !== 1'b1) begin
                bad++; $display("FAIL rand8 a=%0d b=%0d got=%0d/%0b exp=%0d/1", a8, b8, p8, ov8, e8);
            end
            total++;
            if (p16 !== e16 || ov16 !== 1'b1) begin
                bad++; $display("FAIL rand16 a=%0d b=%0d got=%0d/%0b exp=%0d/1", a16, b16, p16, ov16, e16);
            end
        end
        v8 = 1'b0; v16 = 1'b0;
        step();
        total++;
        if (ov8 !== 1'b0 || ov16 !== 1'b0) begin
            bad++; $display("FAIL rand_drain_valid got=%0b/%0b exp=0/0", ov8, ov16);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v4 = 1'b0;  a4 = '0;  b4 = '0;
        v8 = 1'b0;  a8 = '0;  b8 = '0;
        v16 = 1'b0; a16 = '0; b16 = '0;
        test_reset();
        test_directed();
        test_zero_hold();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        test_random_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplier_csa.md
MULTIPLIER_CSA -- requirements
Module: multiplier_csa

Interface
REQ-001 Parameter: N, default 4, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  operands on multiplicand/multiplier valid this cycle.
REQ-005 Port: multiplicand  input  N  unsigned operand A.
REQ-006 Port: multiplier  input  N  unsigned operand B.
REQ-007 Port: product  output  2N  unsigned product A*B, registered.
REQ-008 Port: out_valid  output  1  product holds a new result this cycle.

Function
REQ-009 The block SHALL compute product = multiplicand * multiplier, both unsigned, full 2N-bit result, no truncation or overflow possible.
REQ-010 The multiplication SHALL be a carry-save array: N*N AND-gate partial products, N-1 rows of full adders passing sums down and carries diagonally without intra-row ripple, and one final ripple-carry adder row resolving the remaining sum/carry vectors.
REQ-011 The array and final adder SHALL be purely combinational; the only state is the output register stage.
REQ-012 Latency SHALL be exactly 1 cycle: operands sampled on rising edge k with in_valid=1 appear on product with out_valid=1 after edge k.
REQ-013 out_valid SHALL equal in_valid registered; one result per cycle, full throughput, no backpressure.
REQ-014 When in_valid=0 at an edge, product SHALL hold its previous value and out_valid SHALL go 0.
REQ-015 Back-to-back valid operands SHALL produce back-to-back results in order, each independent of the previous.
REQ-016 Boundary cases: any operand 0 gives 0; all-ones operands give (2^N-1)^2, which is 225 for N=4; operand 1 passes the other operand through unchanged.

Reset
REQ-017 While rst_n=0 at a rising edge, product SHALL become 0 and out_valid SHALL become 0, regardless of in_valid.
REQ-018 Reset asserted mid-stream SHALL discard the in-flight result; the first valid after rst_n returns to 1 SHALL produce its result 1 cycle later.
REQ-019 No asynchronous reset path SHALL exist.

Structure
REQ-020 A single sub-module csa_full_adder (a, b, cin -> sum, cout, combinational) SHALL be instantiated for every array cell and final-adder bit.
REQ-021 The array SHALL be built with generate loops parameterized on N; no hand-unrolled cells.
REQ-022 No shared package is required; N is the only configuration constant and stays a module parameter.

Verification
REQ-023 Reset: hold rst_n=0 for 2 cycles with in_valid=1, A=15, B=15 -> product=0, out_valid=0 throughout.
REQ-024 Directed N=4: A=3,B=5 -> 15; A=15,B=1 -> 15; A=11,B=15 -> 165; A=15,B=15 -> 225; each appears 1 cycle after sampling with out_valid=1.
REQ-025 Zero and hold: A=0,B=13 -> 0; then in_valid=0 for 3 cycles -> product holds 0, out_valid=0.
REQ-026 Back-to-back: valid pairs (7,9), (12,12), (1,0) on consecutive cycles -> 63, 144, 0 on consecutive cycles.
REQ-027 Reset mid-stream: valid (10,10), then rst_n=0 on the next edge -> product=0, out_valid=0, and 100 is never presented.
REQ-028 Exhaustive N=4 (256 pairs) plus 10k random pairs at N=8 and N=16 -> product matches the reference A*B on every valid cycle.
